// File: rtl/main_mem_responder_if.sv
// Miss-request / word-return bus between a cache controller (master)
// and the main-memory responder (slave).
interface main_mem_responder_if #(
  parameter int unsigned DATA_W = 32
);
  logic              miss_req;
  logic [14:0]       miss_addr;
  logic              busy;
  logic              word_valid;
  logic [1:0]        word_offset;
  logic [DATA_W-1:0] word_data;
  logic              ready;

  modport master (
    output miss_req, miss_addr,
    input  busy, word_valid, word_offset, word_data, ready
  );

  modport slave (
    input  miss_req, miss_addr,
    output busy, word_valid, word_offset, word_data, ready
  );
endinterface

// File: rtl/main_mem_responder.sv
// Main-memory model answering block misses: LATENCY wait cycles, a 4-word
// burst in offset order 0..3, then a one-cycle ready pulse.
module main_mem_responder #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  main_mem_responder_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] BURST = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [3:0] WAIT_LOAD = 4'(LATENCY - 1);

  logic [1:0]  state;
  logic [12:0] blk;
  logic [3:0]  wait_cnt;
  logic [1:0]  offset;
  logic        unused_addr_lsb;

  // The backing store holds word[a] = a, so it is realised as its content
  // function instead of a 32768-entry table; it is read-only and reset-free.
  function automatic logic [DATA_W-1:0] rom_word(input logic [14:0] a);
    return DATA_W'(a);
  endfunction

  assign unused_addr_lsb = ^bus.miss_addr[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      blk      <= '0;
      wait_cnt <= '0;
      offset   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.miss_req) begin
            blk      <= bus.miss_addr[14:2];
            wait_cnt <= WAIT_LOAD;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            offset <= '0;
            state  <= BURST;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        BURST: begin
          // Offset parks at 3; only the next fetch brings it back to 0.
          if (offset == 2'd3) state <= DONE;
          else                offset <= offset + 2'd1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.word_valid  = (state == BURST);
  assign bus.word_offset = (state == BURST) ? offset : '0;
  assign bus.word_data   = (state == BURST) ? rom_word({blk, offset}) : '0;
  assign bus.ready       = (state == DONE);

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed bench for main_mem_responder at LATENCY=4 and LATENCY=1, with a
// cycle-count reference model compared every cycle plus literal spot checks.
module tb_main_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [14:0] addr;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  main_mem_responder_if #(.DATA_W(32)) b4 ();
  main_mem_responder_if #(.DATA_W(32)) b1 ();

  assign b4.miss_req  = req;
  assign b4.miss_addr = addr;
  assign b1.miss_req  = req;
  assign b1.miss_addr = addr;

  main_mem_responder #(.LATENCY(4), .DATA_W(32)) dut4 (.clk(clk), .rst(rst), .bus(b4));
  main_mem_responder #(.LATENCY(1), .DATA_W(32)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  logic        ob_busy[2];
  logic        ob_valid[2];
  logic [1:0]  ob_off[2];
  logic [31:0] ob_data[2];
  logic        ob_ready[2];

  assign ob_busy[0]  = b4.busy;        assign ob_busy[1]  = b1.busy;
  assign ob_valid[0] = b4.word_valid;  assign ob_valid[1] = b1.word_valid;
  assign ob_off[0]   = b4.word_offset; assign ob_off[1]   = b1.word_offset;
  assign ob_data[0]  = b4.word_data;   assign ob_data[1]  = b1.word_data;
  assign ob_ready[0] = b4.ready;       assign ob_ready[1] = b1.ready;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", nm, act, exp, $time);
  endtask

  // Reference: a fetch is "k cycles old"; k=1..L wait, L+1..L+4 words, L+5 ready.
  int lat[2] = '{4, 1};
  bit act[2] = '{0, 0};
  int mk[2];
  int mblk[2];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) act[i] = 1'b0;
      else if (act[i]) begin
        if (mk[i] == lat[i] + 5) act[i] = 1'b0;
        else mk[i]++;
      end else if (req) begin
        act[i]  = 1'b1;
        mk[i]   = 1;
        mblk[i] = int'(addr) / 4;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit e_valid;
      int e_off;
      e_valid = act[i] && mk[i] >= lat[i] + 1 && mk[i] <= lat[i] + 4;
      e_off   = e_valid ? mk[i] - lat[i] - 1 : 0;
      chk($sformatf("m%0d_busy", i),  32'(ob_busy[i]),  32'(act[i]));
      chk($sformatf("m%0d_valid", i), 32'(ob_valid[i]), 32'(e_valid));
      chk($sformatf("m%0d_off", i),   32'(ob_off[i]),   32'(e_off));
      chk($sformatf("m%0d_data", i),  ob_data[i],       e_valid ? 32'(mblk[i] * 4 + e_off) : 32'd0);
      chk($sformatf("m%0d_ready", i), 32'(ob_ready[i]), 32'(act[i] && mk[i] == lat[i] + 5));
    end
  end

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Single-cycle request to the LATENCY=4 instance; d0 is the hand-computed first word.
  task automatic walk4(input logic [14:0] a, input logic [31:0] d0, input bit move_addr);
    req = 1'b1; addr = a;
    @(posedge clk); #2 req = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      chk("w4_busy",  32'(b4.busy),       32'(c <= 9));
      chk("w4_valid", 32'(b4.word_valid), 32'(c >= 5 && c <= 8));
      chk("w4_ready", 32'(b4.ready),      32'(c == 9));
      if (c >= 5 && c <= 8) begin
        chk("w4_off",  32'(b4.word_offset), 32'(c - 5));
        chk("w4_data", b4.word_data,        d0 + 32'(c - 5));
      end
      if (move_addr && c == 2) addr = '0;
    end
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy4",  32'(b4.busy),       32'd0);
    chk("rst_valid4", 32'(b4.word_valid), 32'd0);
    chk("rst_data4",  b4.word_data,       32'd0);
    chk("rst_ready4", 32'(b4.ready),      32'd0);
    chk("rst_busy1",  32'(b1.busy),       32'd0);
    @(posedge clk); #2 rst = 1'b0;
    settle(1);

    walk4(15'h0123, 32'h120, 1'b0);  settle(12);
    walk4(15'h7FFD, 32'h7FFC, 1'b0); settle(12);
    walk4(15'h0040, 32'h40, 1'b1);   settle(12);

    // Held request: back-to-back fetches with one idle cycle between them.
    req = 1'b1; addr = 15'h0010;
    @(posedge clk); #2;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      chk("held_busy",  32'(b4.busy),  32'(c != 10));
      chk("held_ready", 32'(b4.ready), 32'(c == 9 || c == 19));
      if (c == 19) req = 1'b0;
    end
    settle(12);

    // Reset mid-burst, just after offset 1 was presented.
    req = 1'b1; addr = 15'h0080;
    @(posedge clk); #2 req = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_abort_off",  32'(b4.word_offset), 32'd1);
    chk("pre_abort_data", b4.word_data,        32'h81);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("abort_busy",  32'(b4.busy),        32'd0);
    chk("abort_valid", 32'(b4.word_valid),  32'd0);
    chk("abort_off",   32'(b4.word_offset), 32'd0);
    chk("abort_data",  b4.word_data,        32'd0);
    chk("abort_ready", 32'(b4.ready),       32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    settle(3);
    walk4(15'h0123, 32'h120, 1'b0); settle(12);

    // LATENCY=1 instance: words on cycles 2..5, ready on cycle 6.
    req = 1'b1; addr = 15'h0004;
    @(posedge clk); #2 req = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      chk("l1_busy",  32'(b1.busy),       32'(c <= 6));
      chk("l1_valid", 32'(b1.word_valid), 32'(c >= 2 && c <= 5));
      chk("l1_ready", 32'(b1.ready),      32'(c == 6));
      if (c >= 2 && c <= 5) chk("l1_data", b1.word_data, 32'h4 + 32'(c - 2));
    end
    settle(12);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/main_mem_responder.md
MAIN_MEM_RESPONDER -- requirements
Module: main_mem_responder

Interface
REQ-001 Parameter LATENCY, default 4: number of wait cycles before the first word is returned; legal range 1..15.
REQ-002 Parameter DATA_W, default 32: word width in bits.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 miss_req  input  1  level request from the cache controller to fetch one block.
REQ-006 miss_addr  input  15  word address of the missing word; bits [14:2] select the block, bits [1:0] are ignored.
REQ-007 busy  output  1  high while a block fetch is in progress (any state other than IDLE).
REQ-008 word_valid  output  1  high for exactly one cycle per returned word.
REQ-009 word_offset  output  2  offset within the block of the word currently on word_data.
REQ-010 word_data  output  DATA_W  returned word; zero whenever word_valid is low.
REQ-011 ready  output  1  one-cycle pulse marking block fetch complete.

Function
REQ-012 Backing store SHALL be a 32768 x DATA_W read-only array, initialised at time zero so that word[a] = a, zero-extended; reset SHALL NOT alter it.
REQ-013 FSM states SHALL be IDLE, WAIT, BURST and DONE; all outputs SHALL be decoded from registered state and counters (Moore).
REQ-014 IDLE: on a clock edge with miss_req=1, latch miss_addr[14:2] into blk, load the wait counter with LATENCY-1, and go to WAIT; with miss_req=0, stay in IDLE.
REQ-015 WAIT: each cycle, if the wait counter is 0, go to BURST with the offset counter at 0; otherwise decrement it; WAIT SHALL last exactly LATENCY cycles.
REQ-016 BURST: word_valid=1, word_offset=offset counter, word_data=word[{blk, offset}]; the offset increments each cycle; after offset 3, go to DONE.
REQ-017 Words SHALL be returned in the fixed order 0,1,2,3, independent of miss_addr[1:0].
REQ-018 DONE: ready=1 for one cycle, word_valid=0, then unconditionally go to IDLE.
REQ-019 busy SHALL be 1 in WAIT, BURST and DONE, and 0 in IDLE; a fetch SHALL occupy exactly LATENCY+5 cycles from the accepting edge.
REQ-020 miss_req and miss_addr SHALL be ignored outside IDLE; changes mid-fetch SHALL NOT affect blk or sequencing.
REQ-021 If miss_req is still 1 in the IDLE cycle following DONE, a new fetch SHALL be accepted (there is no edge detection); the requester deasserts miss_req on ready.
REQ-022 The wait counter SHALL be 4 bits wide and the offset counter 2 bits wide; offset wraps from 3 to 0 only via a new fetch.

Reset
REQ-023 While rst=1, the block SHALL be in state IDLE with all counters and blk at 0, and busy=0, word_valid=0, word_offset=0, word_data=0, ready=0.
REQ-024 Reset asserted mid-fetch SHALL abort it immediately: no further word_valid and no ready pulse for the aborted fetch.
REQ-025 After rst deasserts, the first edge with miss_req=1 SHALL start a fetch normally.

Verification
REQ-026 LATENCY=4: miss_req pulsed for 1 cycle with miss_addr=0x0123 -> busy high for 9 cycles; word_valid on cycles 5..8 after the accepting edge with (offset,data) = (0,0x120),(1,0x121),(2,0x122),(3,0x123); ready on cycle 9.
REQ-027 miss_addr=0x7FFD -> data 0x7FFC..0x7FFF returned in offset order 0..3; no address wrap into block 0.
REQ-028 miss_req held high through ready -> a second identical fetch starts on the edge after DONE, with busy low for exactly one cycle in between.
REQ-029 miss_addr changed to 0x0000 during WAIT of a fetch to 0x0040 -> data 0x40..0x43 returned.
REQ-030 rst asserted during BURST after offset 1 -> all outputs 0 asynchronously, no ready pulse; a fetch after release completes normally.
REQ-031 LATENCY=1: fetch of 0x0004 -> first word_valid on the 2nd cycle after the accepting edge, ready on the 6th cycle.
